// File: rtl/sram_access_ctrl.sv
// Load/store front-end for a 128x32 SRAM macro: one byte-addressed access in flight,
// registered macro strobes, aligned and extended load data returned over valid/ready.
module sram_access_ctrl #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [6:0]  sram_addr_sel,
  output logic [3:0]  sram_byte_sel,
  output logic        sram_read_pulse,
  output logic        sram_write_pulse,
  output logic [31:0] sram_datain,
  input  logic [31:0] sram_dataout,
  input  logic        sram_flg_complete
);

  // state | meaning
  // IDLE  | ready; accepts and latches a request
  // SETUP | address, lanes and write data settle at the macro, strobes low
  // PULSE | read or write strobe high for PULSE_CYCLES cycles
  // HOLD  | strobes low, waiting for the macro completion flag (bounded by TIMEOUT)
  // RESP  | response presented until the consumer takes it
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int unsigned TMAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int          TW   = $clog2(TMAX + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    lanes_q, lanes_d;
  logic [31:0]   din_q, din_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req_illegal;
  logic [3:0]    req_lanes;
  logic [31:0]   req_data;
  logic [31:0]   lane_word;
  logic [31:0]   load_data;

  always_comb begin
    req_illegal = 1'b0;
    case (req_size)
      2'b01:   req_illegal = req_addr[0];
      2'b10:   req_illegal = (req_addr[1:0] != 2'b00);
      2'b11:   req_illegal = 1'b1;
      default: req_illegal = 1'b0;
    endcase
    if (req_addr[31:9] != BASE_ADDR[31:9]) req_illegal = 1'b1;
  end

  // Narrow stores replicate the data across the word so the lane enables alone pick the bytes.
  always_comb begin
    case (req_size)
      2'b00: begin
        req_lanes = 4'b0001 << req_addr[1:0];
        req_data  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_lanes = 4'b0011 << req_addr[1:0];
        req_data  = {2{req_wdata[15:0]}};
      end
      default: begin
        req_lanes = 4'b1111;
        req_data  = req_wdata;
      end
    endcase
  end

  always_comb begin
    lane_word = sram_dataout >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, lane_word[7:0]}
                                 : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, lane_word[15:0]}
                                 : {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          rdata_d = 32'h0;
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = req_addr[8:2];
            lanes_d = req_lanes;
            din_d   = req_data;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        tmr_d   = TW'(PULSE_CYCLES);
        rd_d    = ~we_q;
        wr_d    = we_q;
        state_d = PULSE;
      end
      PULSE: begin
        if (tmr_q == TW'(1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          tmr_d   = TW'(TIMEOUT);
          state_d = HOLD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      HOLD: begin
        if (sram_flg_complete) begin
          rdata_d = we_q ? 32'h0 : load_data;
          state_d = RESP;
        end else if (tmr_q == TW'(1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          addr_d  = 7'h0;
          lanes_d = 4'h0;
          din_d   = 32'h0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= 7'h0;
      lanes_q <= 4'h0;
      din_q   <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      lanes_q <= lanes_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign sram_addr_sel    = addr_q;
  assign sram_byte_sel    = lanes_q;
  assign sram_datain      = din_q;
  assign sram_read_pulse  = rd_q;
  assign sram_write_pulse = wr_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: a byte-array reference model and a simple 128x32 macro
// model, directed scenarios plus randomized load/store traffic.
module tb_sram_access_ctrl;
  localparam int P = 2;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [6:0]  sram_addr_sel;
  logic [3:0]  sram_byte_sel;
  logic        sram_read_pulse, sram_write_pulse;
  logic [31:0] sram_datain, sram_dataout;
  logic        sram_flg_complete;

  logic [31:0] mem [128];
  logic [7:0]  ref_bytes [512];
  logic        flag_en;
  logic        fill_mem;
  int          checks = 0;
  int          errors = 0;

  sram_access_ctrl #(.PULSE_CYCLES(P), .BASE_ADDR(32'h0), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_addr_sel(sram_addr_sel), .sram_byte_sel(sram_byte_sel),
    .sram_read_pulse(sram_read_pulse), .sram_write_pulse(sram_write_pulse),
    .sram_datain(sram_datain), .sram_dataout(sram_dataout),
    .sram_flg_complete(sram_flg_complete)
  );

  always #5 clk = ~clk;

  assign sram_flg_complete = flag_en;
  assign sram_dataout      = mem[sram_addr_sel];

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_word(i);
    end else if (sram_write_pulse) begin
      for (int i = 0; i < 4; i++)
        if (sram_byte_sel[i]) mem[sram_addr_sel][8*i +: 8] <= sram_datain[8*i +: 8];
    end
  end

  // Reference model: byte-addressed little-endian array
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (addr[31:9] != 23'h0) return 1'b1;
    if ((addr % 32'(nbytes(size))) != 32'h0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    int n;
    int a;
    logic [31:0] v;
    n = nbytes(size);
    a = int'(addr[8:0]);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int n;
    int a;
    n = nbytes(size);
    a = int'(addr[8:0]);
    for (int i = 0; i < n; i++) ref_bytes[a + i] = wdata[8*i +: 8];
  endtask

  // Runs one transaction and reports observations; callers do the comparisons.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic rdy0, output int lat, output logic [31:0] rdata,
                        output logic err, output int rd_cnt, output int wr_cnt,
                        output int ovl, output int bad, output int hold_bad);
    int n;
    int l;
    logic [3:0]  lanes;
    logic [31:0] din;
    n = nbytes(size);
    l = ((1 << n) - 1) << addr[1:0];
    lanes = l[3:0];
    din = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
    lat = -1; rdata = 32'h0; err = 1'b0;
    rd_cnt = 0; wr_cnt = 0; ovl = 0; bad = 0; hold_bad = 0;
    @(negedge clk);
    rdy0 = req_ready;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (sram_read_pulse && sram_write_pulse) ovl++;
      if (sram_read_pulse) rd_cnt++;
      if (sram_write_pulse) wr_cnt++;
      if ((sram_read_pulse || sram_write_pulse) &&
          (sram_addr_sel !== addr[8:2] || sram_byte_sel !== lanes ||
           (we && sram_datain !== din))) bad++;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    if (lat > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
            req_ready !== 1'b0) hold_bad++;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      resp_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fill_mem = 1'b1; flag_en = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    for (int i = 0; i < 128; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = seed_word(i)[8*b +: 8];
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; fill_mem = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    checks++;
    if ({resp_valid, resp_err, sram_read_pulse, sram_write_pulse} !== 4'b0 ||
        resp_rdata !== 32'h0 || sram_addr_sel !== 7'h0 || sram_byte_sel !== 4'h0 ||
        sram_datain !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b err=%b rd=%b wr=%b rdata=%h addr=%h lanes=%h din=%h expected all 0",
               resp_valid, resp_err, sram_read_pulse, sram_write_pulse, resp_rdata,
               sram_addr_sel, sram_byte_sel, sram_datain);
    end
  endtask

  task automatic test_directed();
    logic rdy0, err; int lat, rdc, wrc, ovl, bad, hb; logic [31:0] rd;
    logic [31:0] exp_vals [3];
    logic        exp_uns  [3];
    exp_vals[0] = 32'hDEAD_BEEF; exp_vals[1] = 32'hFFFF_FF80; exp_vals[2] = 32'h0000_0080;
    exp_uns[0]  = 1'b0;          exp_uns[1]  = 1'b0;          exp_uns[2]  = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
    ref_store(2'b10, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (lat != P + 3 || err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL store_word_resp: got lat=%0d err=%b rdata=%h expected lat=%0d err=0 rdata=0",
                         lat, err, rd, P + 3);
    end
    checks++;
    if (wrc != P || rdc != 0 || bad != 0) begin
      errors++; $display("FAIL store_word_pulse: got wr=%0d rd=%0d bad=%0d expected wr=%0d rd=0 bad=0",
                         wrc, rdc, bad, P);
    end

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
    checks++;
    if (rd !== exp_vals[0] || err !== 1'b0 || lat != P + 3) begin
      errors++; $display("FAIL load_word: got rdata=%h err=%b lat=%0d expected rdata=%h err=0 lat=%0d",
                         rd, err, lat, exp_vals[0], P + 3);
    end
    checks++;
    if (rdc != P || wrc != 0 || bad != 0) begin
      errors++; $display("FAIL load_word_pulse: got rd=%0d wr=%0d bad=%0d expected rd=%0d wr=0 bad=0",
                         rdc, wrc, bad, P);
    end

    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
    ref_store(2'b00, 32'h13, 32'h0000_0080);
    checks++;
    if (err !== 1'b0 || wrc != P || bad != 0) begin
      errors++; $display("FAIL store_byte: got err=%b wr=%0d bad=%0d expected err=0 wr=%0d bad=0",
                         err, wrc, bad, P);
    end
    for (int i = 1; i < 3; i++) begin
      do_req(1'b0, 2'b00, exp_uns[i], 32'h13, 32'h0, 0, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
      checks++;
      if (rd !== exp_vals[i] || err !== 1'b0 || bad != 0) begin
        errors++; $display("FAIL load_byte_uns%0b: got rdata=%h err=%b bad=%0d expected rdata=%h err=0 bad=0",
                           exp_uns[i], rd, err, bad, exp_vals[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic rdy0, err; int lat, rdc, wrc, ovl, bad, hb; logic [31:0] rd;
    logic        we_t   [6];
    logic [1:0]  size_t [6];
    logic [31:0] addr_t [6];
    we_t[0] = 0; size_t[0] = 2'b01; addr_t[0] = 32'h11;
    we_t[1] = 0; size_t[1] = 2'b01; addr_t[1] = 32'h200;
    we_t[2] = 0; size_t[2] = 2'b11; addr_t[2] = 32'h0;
    we_t[3] = 0; size_t[3] = 2'b10; addr_t[3] = 32'h12;
    we_t[4] = 1; size_t[4] = 2'b10; addr_t[4] = 32'h3;
    we_t[5] = 1; size_t[5] = 2'b00; addr_t[5] = 32'h8000_0004;
    for (int i = 0; i < 6; i++) begin
      do_req(we_t[i], size_t[i], 1'b0, addr_t[i], 32'hFFFF_FFFF, 0,
             rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
      checks++;
      if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || rdc != 0 || wrc != 0) begin
        errors++; $display("FAIL err_case%0d: got lat=%0d err=%b rdata=%h rd=%0d wr=%0d expected lat=1 err=1 rdata=0 rd=0 wr=0",
                           i, lat, err, rd, rdc, wrc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy0, err; int lat, rdc, wrc, ovl, bad, hb; logic [31:0] rd;
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
    checks++;
    if (hb != 0 || rd !== exp_load(2'b01, 1'b0, 32'h12) || lat != P + 3) begin
      errors++; $display("FAIL backpressure: got unstable=%0d rdata=%h lat=%0d expected unstable=0 rdata=%h lat=%0d",
                         hb, rd, lat, exp_load(2'b01, 1'b0, 32'h12), P + 3);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: got valid=%b ready=%b expected valid=0 ready=1",
                         resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10; resp_ready = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (sram_read_pulse !== 1'b1) begin
      errors++; $display("FAIL rstmid_pulse_before: got %b expected 1", sram_read_pulse);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sram_read_pulse !== 1'b0 || sram_write_pulse !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_pulse_drop: got rd=%b wr=%b valid=%b expected 0 0 0",
                         sram_read_pulse, sram_write_pulse, resp_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid || sram_read_pulse) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: got activity=%0d ready=%b expected activity=0 ready=1",
                         seen, req_ready);
    end
  endtask

  task automatic test_timeout();
    logic rdy0, err; int lat, rdc, wrc, ovl, bad, hb; logic [31:0] rd;
    flag_en = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
    flag_en = 1'b1;
    checks++;
    if (lat != P + 2 + T || err !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL timeout_resp: got lat=%0d err=%b rdata=%h expected lat=%0d err=1 rdata=0",
                         lat, err, rd, P + 2 + T);
    end
    checks++;
    if (rdc != P || ovl != 0) begin
      errors++; $display("FAIL timeout_pulse: got rd=%0d overlap=%0d expected rd=%0d overlap=0",
                         rdc, ovl, P);
    end
  endtask

  task automatic test_random();
    logic rdy0, err, we, uns, e; int lat, rdc, wrc, ovl, bad, hb; logic [31:0] rd;
    logic [1:0]  size;
    logic [31:0] addr, wdata, exp_rd;
    int          exp_lat;
    for (int t = 0; t < 60; t++) begin
      we    = 1'($urandom);
      uns   = 1'($urandom);
      size  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if ($urandom_range(0, 9) == 0) addr = {23'($urandom_range(1, 32'h7F_FFFF)), 9'($urandom)};
      else                           addr = {23'h0, 9'($urandom)};
      e       = exp_err(size, addr);
      exp_rd  = (e || we) ? 32'h0 : exp_load(size, uns, addr);
      exp_lat = e ? 1 : P + 3;
      do_req(we, size, uns, addr, wdata, 0, rdy0, lat, rd, err, rdc, wrc, ovl, bad, hb);
      if (!e && we) ref_store(size, addr, wdata);
      checks++;
      if (rdy0 !== 1'b1 || lat != exp_lat || err !== e || rd !== exp_rd) begin
        errors++; $display("FAIL rand%0d we=%b size=%0d addr=%h: got ready=%b lat=%0d err=%b rdata=%h expected ready=1 lat=%0d err=%b rdata=%h",
                           t, we, size, addr, rdy0, lat, err, rd, exp_lat, e, exp_rd);
      end
      checks++;
      if (ovl != 0 || bad != 0 || rdc != ((e || we) ? 0 : P) || wrc != ((e || !we) ? 0 : P)) begin
        errors++; $display("FAIL rand%0d_pulse: got rd=%0d wr=%0d overlap=%0d bad=%0d expected rd=%0d wr=%0d overlap=0 bad=0",
                           t, rdc, wrc, ovl, bad, (e || we) ? 0 : P, (e || !we) ? 0 : P);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
